// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: registered ID->EX control unit for the 5-stage MIPS pipeline.
// Decodes the ID instruction into the EX control word. It also inserts a
// one-cycle bubble on a load-use hazard. It tracks the multi-cycle MULT/DIV
// unit so that dependent HI/LO accesses wait, and it kills the ID instruction
// when a branch in EX is taken.
// Optional feature: define CTRL_ILLEGAL_EN to add the ex_illegal output, which
// flags unknown opcodes or unknown R-type functs.
// MD_LATENCY must lie in 1..15; md_cnt is 4 bits wide.

module pipe_ctrl_unit #(
  parameter int MD_LATENCY = 4,
  parameter int ALUOP_W    = 4,
  parameter int RA_W       = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [5:0]          id_opcode,
  input  logic [5:0]          id_funct,
  input  logic [RA_W-1:0]     id_rs,
  input  logic [RA_W-1:0]     id_rt,
  input  logic [RA_W-1:0]     id_rd,
  input  logic                flush,
  output logic                stall_id,
  output logic                md_busy,
  output logic                ex_reg_write,
  output logic [1:0]          ex_reg_dst,
  output logic [RA_W-1:0]     ex_wreg,
  output logic                ex_alu_src,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_mem_to_reg,
  output logic                ex_branch,
  output logic [ALUOP_W-1:0]  ex_alu_op,
  output logic [2:0]          ex_load_op,
  output logic [1:0]          ex_save_op,
  output logic                ex_md_start
`ifdef CTRL_ILLEGAL_EN
  ,
  output logic                ex_illegal
`endif
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LH     = 6'b100001;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_LBU    = 6'b100100;
  localparam logic [5:0] OP_LHU    = 6'b100101;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SH     = 6'b101001;
  localparam logic [5:0] OP_SW     = 6'b101011;

  // R-type functs that need special handling
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  localparam logic [1:0] DST_RT  = 2'b00;
  localparam logic [1:0] DST_RD  = 2'b01;
  localparam logic [1:0] DST_R31 = 2'b10;

  localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY);

  // Decoded control word (combinational)
  logic               dec_reg_write;
  logic [1:0]         dec_reg_dst;
  logic [RA_W-1:0]    dec_wreg;
  logic               dec_alu_src;
  logic               dec_mem_read;
  logic               dec_mem_write;
  logic               dec_mem_to_reg;
  logic               dec_branch;
  logic [ALUOP_W-1:0] dec_alu_op;
  logic [2:0]         dec_load_op;
  logic [1:0]         dec_save_op;
  logic               dec_legal;
  logic               dec_rt_used;
  logic               dec_is_md;
  logic               dec_is_hilo;
  logic               rtype_known;

  // Hazard / sequencing signals
  logic load_use;
  logic hilo_wait;
  logic advance;
  logic take_word;

  // Registered state
  logic               ex_reg_write_q,  ex_reg_write_d;
  logic [1:0]         ex_reg_dst_q,    ex_reg_dst_d;
  logic [RA_W-1:0]    ex_wreg_q,       ex_wreg_d;
  logic               ex_alu_src_q,    ex_alu_src_d;
  logic               ex_mem_read_q,   ex_mem_read_d;
  logic               ex_mem_write_q,  ex_mem_write_d;
  logic               ex_mem_to_reg_q, ex_mem_to_reg_d;
  logic               ex_branch_q,     ex_branch_d;
  logic [ALUOP_W-1:0] ex_alu_op_q,     ex_alu_op_d;
  logic [2:0]         ex_load_op_q,    ex_load_op_d;
  logic [1:0]         ex_save_op_q,    ex_save_op_d;
  logic               ex_md_start_q,   ex_md_start_d;
  logic [3:0]         md_cnt_q,        md_cnt_d;
  logic               md_busy_q,       md_busy_d;
`ifdef CTRL_ILLEGAL_EN
  logic               ex_illegal_q,    ex_illegal_d;
`endif

  // Classify R-type functs: known or not, and whether they touch HI/LO
  always_comb begin
    rtype_known = 1'b1;
    dec_is_md   = 1'b0;
    dec_is_hilo = 1'b0;
    unique case (id_funct)
      6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
      FN_JR, 6'b001001,
      6'b100000, 6'b100001, 6'b100010, 6'b100011,
      6'b100100, 6'b100101, 6'b100110, 6'b100111,
      6'b101010, 6'b101011: rtype_known = 1'b1;
      FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO: dec_is_hilo = 1'b1;
      FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
        dec_is_hilo = 1'b1;
        dec_is_md   = 1'b1;
      end
      default: rtype_known = 1'b0;
    endcase
    if (id_opcode != OP_RTYPE) begin
      dec_is_md   = 1'b0;
      dec_is_hilo = 1'b0;
    end
  end

  // Main decoder: opcode/funct/rt to control word, defaulting to the NOP word
  always_comb begin
    dec_reg_write  = 1'b0;
    dec_reg_dst    = DST_RT;
    dec_alu_src    = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_branch     = 1'b0;
    dec_alu_op     = '1;
    dec_load_op    = 3'b111;
    dec_save_op    = 2'b11;
    dec_legal      = 1'b1;
    dec_rt_used    = 1'b0;
    unique case (id_opcode)
      OP_RTYPE: begin
        dec_rt_used = 1'b1;
        if (rtype_known) begin
          dec_reg_write = (id_funct != FN_JR);
          dec_reg_dst   = DST_RD;
          dec_alu_op    = ALUOP_W'(4'b0000);
        end else begin
          dec_legal = 1'b0;
        end
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_LUI: begin
        dec_reg_write = 1'b1;
        dec_reg_dst   = DST_RT;
        dec_alu_src   = 1'b1;
        unique case (id_opcode)
          OP_ADDI, OP_ADDIU: dec_alu_op = ALUOP_W'(4'b1001);
          OP_ANDI:           dec_alu_op = ALUOP_W'(4'b1010);
          OP_ORI:            dec_alu_op = ALUOP_W'(4'b1011);
          OP_XORI:           dec_alu_op = ALUOP_W'(4'b1100);
          OP_SLTI, OP_SLTIU: dec_alu_op = ALUOP_W'(4'b1101);
          default:           dec_alu_op = ALUOP_W'(4'b1000);
        endcase
      end
      OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: begin
        dec_reg_write  = 1'b1;
        dec_reg_dst    = DST_RT;
        dec_alu_src    = 1'b1;
        dec_mem_read   = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_alu_op     = ALUOP_W'(4'b0111);
        unique case (id_opcode)
          OP_LW:   dec_load_op = 3'b000;
          OP_LB:   dec_load_op = 3'b001;
          OP_LBU:  dec_load_op = 3'b010;
          OP_LH:   dec_load_op = 3'b011;
          default: dec_load_op = 3'b100;
        endcase
      end
      OP_SW, OP_SB, OP_SH: begin
        dec_rt_used   = 1'b1;
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
        dec_alu_op    = ALUOP_W'(4'b0111);
        unique case (id_opcode)
          OP_SW:   dec_save_op = 2'b00;
          OP_SB:   dec_save_op = 2'b01;
          default: dec_save_op = 2'b10;
        endcase
      end
      OP_BEQ: begin
        dec_branch  = 1'b1;
        dec_rt_used = 1'b1;
        dec_alu_op  = ALUOP_W'(4'b0001);
      end
      OP_BNE: begin
        dec_branch  = 1'b1;
        dec_rt_used = 1'b1;
        dec_alu_op  = ALUOP_W'(4'b0110);
      end
      OP_BGTZ: begin
        dec_branch = 1'b1;
        dec_alu_op = ALUOP_W'(4'b0011);
      end
      OP_BLEZ: begin
        dec_branch = 1'b1;
        dec_alu_op = ALUOP_W'(4'b0100);
      end
      OP_REGIMM: begin
        if (id_rt == RA_W'(1)) begin
          dec_branch = 1'b1;
          dec_alu_op = ALUOP_W'(4'b0010);
        end else if (id_rt == RA_W'(0)) begin
          dec_branch = 1'b1;
          dec_alu_op = ALUOP_W'(4'b0101);
        end else begin
          dec_legal = 1'b0;
        end
      end
      OP_JAL: begin
        dec_reg_write = 1'b1;
        dec_reg_dst   = DST_R31;
      end
      OP_J: begin
        dec_legal = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Resolve the destination register; zero whenever nothing is written
  always_comb begin
    dec_wreg = '0;
    if (dec_reg_write) begin
      unique case (dec_reg_dst)
        DST_RT:  dec_wreg = id_rt;
        DST_RD:  dec_wreg = id_rd;
        DST_R31: dec_wreg = {RA_W{1'b1}};
        default: dec_wreg = '0;
      endcase
    end
  end

  // Stall and advance decisions. The MULT/DIV unit is free at the edge where
  // md_cnt goes 1 -> 0, so a waiting HI/LO op may advance on that same edge.
  always_comb begin
    load_use  = id_valid & ex_mem_read_q & (ex_wreg_q != '0) &
                ((ex_wreg_q == id_rs) | (dec_rt_used & (ex_wreg_q == id_rt)));
    hilo_wait = id_valid & dec_is_hilo & md_busy_q & (md_cnt_q != 4'd1);
    stall_id  = !flush & (load_use | hilo_wait);
    advance   = !flush & !stall_id & id_valid;
    take_word = advance & dec_legal;
  end

  // Next EX control word: the decoded word on advance, otherwise a NOP bubble
  always_comb begin
    ex_reg_write_d  = 1'b0;
    ex_reg_dst_d    = DST_RT;
    ex_wreg_d       = '0;
    ex_alu_src_d    = 1'b0;
    ex_mem_read_d   = 1'b0;
    ex_mem_write_d  = 1'b0;
    ex_mem_to_reg_d = 1'b0;
    ex_branch_d     = 1'b0;
    ex_alu_op_d     = '1;
    ex_load_op_d    = 3'b111;
    ex_save_op_d    = 2'b11;
    ex_md_start_d   = 1'b0;
    if (take_word) begin
      ex_reg_write_d  = dec_reg_write;
      ex_reg_dst_d    = dec_reg_dst;
      ex_wreg_d       = dec_wreg;
      ex_alu_src_d    = dec_alu_src;
      ex_mem_read_d   = dec_mem_read;
      ex_mem_write_d  = dec_mem_write;
      ex_mem_to_reg_d = dec_mem_to_reg;
      ex_branch_d     = dec_branch;
      ex_alu_op_d     = dec_alu_op;
      ex_load_op_d    = dec_load_op;
      ex_save_op_d    = dec_save_op;
      ex_md_start_d   = dec_is_md;
    end
  end

  // MULT/DIV occupancy counter; an already-issued op keeps counting through flushes
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (take_word & dec_is_md) begin
      md_cnt_d = MD_LOAD;
    end else if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end
    md_busy_d = (md_cnt_d != 4'd0);
  end

`ifdef CTRL_ILLEGAL_EN
  // Flag an unknown encoding that would otherwise have advanced
  always_comb begin
    ex_illegal_d = advance & !dec_legal;
  end
`endif

  // State register for the EX control word and the MULT/DIV tracker
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_reg_write_q  <= 1'b0;
      ex_reg_dst_q    <= DST_RT;
      ex_wreg_q       <= '0;
      ex_alu_src_q    <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      ex_mem_write_q  <= 1'b0;
      ex_mem_to_reg_q <= 1'b0;
      ex_branch_q     <= 1'b0;
      ex_alu_op_q     <= '1;
      ex_load_op_q    <= 3'b111;
      ex_save_op_q    <= 2'b11;
      ex_md_start_q   <= 1'b0;
      md_cnt_q        <= 4'd0;
      md_busy_q       <= 1'b0;
`ifdef CTRL_ILLEGAL_EN
      ex_illegal_q    <= 1'b0;
`endif
    end else begin
      ex_reg_write_q  <= ex_reg_write_d;
      ex_reg_dst_q    <= ex_reg_dst_d;
      ex_wreg_q       <= ex_wreg_d;
      ex_alu_src_q    <= ex_alu_src_d;
      ex_mem_read_q   <= ex_mem_read_d;
      ex_mem_write_q  <= ex_mem_write_d;
      ex_mem_to_reg_q <= ex_mem_to_reg_d;
      ex_branch_q     <= ex_branch_d;
      ex_alu_op_q     <= ex_alu_op_d;
      ex_load_op_q    <= ex_load_op_d;
      ex_save_op_q    <= ex_save_op_d;
      ex_md_start_q   <= ex_md_start_d;
      md_cnt_q        <= md_cnt_d;
      md_busy_q       <= md_busy_d;
`ifdef CTRL_ILLEGAL_EN
      ex_illegal_q    <= ex_illegal_d;
`endif
    end
  end

  assign ex_reg_write  = ex_reg_write_q;
  assign ex_reg_dst    = ex_reg_dst_q;
  assign ex_wreg       = ex_wreg_q;
  assign ex_alu_src    = ex_alu_src_q;
  assign ex_mem_read   = ex_mem_read_q;
  assign ex_mem_write  = ex_mem_write_q;
  assign ex_mem_to_reg = ex_mem_to_reg_q;
  assign ex_branch     = ex_branch_q;
  assign ex_alu_op     = ex_alu_op_q;
  assign ex_load_op    = ex_load_op_q;
  assign ex_save_op    = ex_save_op_q;
  assign ex_md_start   = ex_md_start_q;
  assign md_busy       = md_busy_q;
`ifdef CTRL_ILLEGAL_EN
  assign ex_illegal    = ex_illegal_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: scoreboard bench for pipe_ctrl_unit (MD_LATENCY = 4).
// Builds with or without CTRL_ILLEGAL_EN.

module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [5:0] id_opcode;
  logic [5:0] id_funct;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [4:0] id_rd;
  logic       flush;
  logic       stall_id;
  logic       md_busy;
  logic       ex_reg_write;
  logic [1:0] ex_reg_dst;
  logic [4:0] ex_wreg;
  logic       ex_alu_src;
  logic       ex_mem_read;
  logic       ex_mem_write;
  logic       ex_mem_to_reg;
  logic       ex_branch;
  logic [3:0] ex_alu_op;
  logic [2:0] ex_load_op;
  logic [1:0] ex_save_op;
  logic       ex_md_start;
`ifdef CTRL_ILLEGAL_EN
  logic       ex_illegal;
`endif

  typedef struct packed {
    logic       rw;
    logic [1:0] dst;
    logic [4:0] wreg;
    logic       src;
    logic       mr;
    logic       mw;
    logic       m2r;
    logic       br;
    logic [3:0] alu;
    logic [2:0] ld;
    logic [1:0] sv;
    logic       mds;
    logic       busy;
`ifdef CTRL_ILLEGAL_EN
    logic       ill;
`endif
  } word_t;

  word_t exp_q[$];
  string name_q[$];
  int    tests_run    = 0;
  int    tests_failed = 0;

  pipe_ctrl_unit #(.MD_LATENCY(4), .ALUOP_W(4), .RA_W(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .flush(flush), .stall_id(stall_id), .md_busy(md_busy),
    .ex_reg_write(ex_reg_write), .ex_reg_dst(ex_reg_dst), .ex_wreg(ex_wreg),
    .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_branch(ex_branch), .ex_alu_op(ex_alu_op), .ex_load_op(ex_load_op),
    .ex_save_op(ex_save_op), .ex_md_start(ex_md_start)
`ifdef CTRL_ILLEGAL_EN
    , .ex_illegal(ex_illegal)
`endif
  );

  always #5 clk = ~clk;

  function automatic word_t mk(input logic rw, input logic [1:0] dst,
                               input logic [4:0] wreg, input logic src,
                               input logic mr, input logic mw, input logic m2r,
                               input logic br, input logic [3:0] alu,
                               input logic [2:0] ld, input logic [1:0] sv,
                               input logic mds, input logic busy);
    word_t w;
    w      = '0;
    w.rw   = rw;   w.dst = dst; w.wreg = wreg; w.src = src;
    w.mr   = mr;   w.mw  = mw;  w.m2r  = m2r;  w.br  = br;
    w.alu  = alu;  w.ld  = ld;  w.sv   = sv;   w.mds = mds;
    w.busy = busy;
    return w;
  endfunction

  function automatic word_t nop(input logic busy);
    return mk(0, 2'b00, 5'd0, 0, 0, 0, 0, 0, 4'hF, 3'h7, 2'h3, 0, busy);
  endfunction

  // NOP word that additionally carries the illegal flag when the feature is built
  function automatic word_t nop_ill();
    word_t w;
    w = nop(1'b0);
`ifdef CTRL_ILLEGAL_EN
    w.ill = 1'b1;
`endif
    return w;
  endfunction

  function automatic word_t actual_word();
    word_t w;
    w = mk(ex_reg_write, ex_reg_dst, ex_wreg, ex_alu_src, ex_mem_read,
           ex_mem_write, ex_mem_to_reg, ex_branch, ex_alu_op, ex_load_op,
           ex_save_op, ex_md_start, md_busy);
`ifdef CTRL_ILLEGAL_EN
    w.ill = ex_illegal;
`endif
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Drive one ID cycle, check stall_id combinationally, queue the EX word expected after the edge
  task automatic applyStimulus(input string name, input logic v,
                               input logic [5:0] op, input logic [5:0] fn,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic fl,
                               input logic exp_stall, input word_t exp_w);
    @(negedge clk);
    id_valid  = v;
    id_opcode = op;
    id_funct  = fn;
    id_rs     = rs;
    id_rt     = rt;
    id_rd     = rd;
    flush     = fl;
    #1;
    checkOutput({name, " stall"}, 32'(stall_id), 32'(exp_stall));
    exp_q.push_back(exp_w);
    name_q.push_back(name);
    @(posedge clk);
  endtask

  // Monitor: after every edge, pop and compare the word the DUT now presents
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        checkOutput(name_q.pop_front(), 32'(actual_word()), 32'(exp_q.pop_front()));
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; id_valid = 0; id_opcode = 0; id_funct = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; flush = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset word", 32'(actual_word()), 32'(nop(1'b0)));
    rst = 1'b0;

    // Decode sweep (rs=1, rt=2, rd=3; loads target r8)
    applyStimulus("ADD",   1, 6'h00, 6'h20, 1, 2, 3, 0, 0, mk(1,2'b01,3,0,0,0,0,0,4'h0,7,3,0,0));
    applyStimulus("JR",    1, 6'h00, 6'h08, 1, 2, 3, 0, 0, mk(0,2'b01,0,0,0,0,0,0,4'h0,7,3,0,0));
    applyStimulus("JALR",  1, 6'h00, 6'h09, 1, 2, 3, 0, 0, mk(1,2'b01,3,0,0,0,0,0,4'h0,7,3,0,0));
    applyStimulus("ADDI",  1, 6'h08, 6'h00, 1, 2, 3, 0, 0, mk(1,2'b00,2,1,0,0,0,0,4'h9,7,3,0,0));
    applyStimulus("ADDIU", 1, 6'h09, 6'h00, 1, 2, 3, 0, 0, mk(1,2'b00,2,1,0,0,0,0,4'h9,7,3,0,0));
    applyStimulus("SLTI",  1, 6'h0A, 6'h00, 1, 2, 3, 0, 0, mk(1,2'b00,2,1,0,0,0,0,4'hD,7,3,0,0));
    applyStimulus("SLTIU", 1, 6'h0B, 6'h00, 1, 2, 3, 0, 0, mk(1,2'b00,2,1,0,0,0,0,4'hD,7,3,0,0));
    applyStimulus("ANDI",  1, 6'h0C, 6'h00, 1, 2, 3, 0, 0, mk(1,2'b00,2,1,0,0,0,0,4'hA,7,3,0,0));
    applyStimulus("ORI",   1, 6'h0D, 6'h00, 1, 2, 3, 0, 0, mk(1,2'b00,2,1,0,0,0,0,4'hB,7,3,0,0));
    applyStimulus("XORI",  1, 6'h0E, 6'h00, 1, 2, 3, 0, 0, mk(1,2'b00,2,1,0,0,0,0,4'hC,7,3,0,0));
    applyStimulus("LUI",   1, 6'h0F, 6'h00, 1, 2, 3, 0, 0, mk(1,2'b00,2,1,0,0,0,0,4'h8,7,3,0,0));
    applyStimulus("LW",    1, 6'h23, 6'h00, 1, 8, 3, 0, 0, mk(1,2'b00,8,1,1,0,1,0,4'h7,0,3,0,0));
    applyStimulus("LB",    1, 6'h20, 6'h00, 1, 8, 3, 0, 0, mk(1,2'b00,8,1,1,0,1,0,4'h7,1,3,0,0));
    applyStimulus("LBU",   1, 6'h24, 6'h00, 1, 8, 3, 0, 0, mk(1,2'b00,8,1,1,0,1,0,4'h7,2,3,0,0));
    applyStimulus("LH",    1, 6'h21, 6'h00, 1, 8, 3, 0, 0, mk(1,2'b00,8,1,1,0,1,0,4'h7,3,3,0,0));
    applyStimulus("LHU",   1, 6'h25, 6'h00, 1, 8, 3, 0, 0, mk(1,2'b00,8,1,1,0,1,0,4'h7,4,3,0,0));
    applyStimulus("SW",    1, 6'h2B, 6'h00, 1, 2, 3, 0, 0, mk(0,2'b00,0,1,0,1,0,0,4'h7,7,0,0,0));
    applyStimulus("SB",    1, 6'h28, 6'h00, 1, 2, 3, 0, 0, mk(0,2'b00,0,1,0,1,0,0,4'h7,7,1,0,0));
    applyStimulus("SH",    1, 6'h29, 6'h00, 1, 2, 3, 0, 0, mk(0,2'b00,0,1,0,1,0,0,4'h7,7,2,0,0));
    applyStimulus("BEQ",   1, 6'h04, 6'h00, 1, 2, 3, 0, 0, mk(0,2'b00,0,0,0,0,0,1,4'h1,7,3,0,0));
    applyStimulus("BNE",   1, 6'h05, 6'h00, 1, 2, 3, 0, 0, mk(0,2'b00,0,0,0,0,0,1,4'h6,7,3,0,0));
    applyStimulus("BGTZ",  1, 6'h07, 6'h00, 1, 0, 3, 0, 0, mk(0,2'b00,0,0,0,0,0,1,4'h3,7,3,0,0));
    applyStimulus("BLEZ",  1, 6'h06, 6'h00, 1, 0, 3, 0, 0, mk(0,2'b00,0,0,0,0,0,1,4'h4,7,3,0,0));
    applyStimulus("BGEZ",  1, 6'h01, 6'h00, 1, 1, 3, 0, 0, mk(0,2'b00,0,0,0,0,0,1,4'h2,7,3,0,0));
    applyStimulus("BLTZ",  1, 6'h01, 6'h00, 1, 0, 3, 0, 0, mk(0,2'b00,0,0,0,0,0,1,4'h5,7,3,0,0));
    applyStimulus("JAL",   1, 6'h03, 6'h00, 1, 2, 3, 0, 0, mk(1,2'b10,31,0,0,0,0,0,4'hF,7,3,0,0));
    applyStimulus("op 3F", 1, 6'h3F, 6'h00, 1, 2, 3, 0, 0, nop_ill());
    applyStimulus("bad fn",1, 6'h00, 6'h01, 1, 2, 3, 0, 0, nop_ill());
    applyStimulus("invalid", 0, 6'h00, 6'h20, 1, 2, 3, 0, 0, nop(0));

    // Load-use hazards on r5
    applyStimulus("LW r5 a",   1, 6'h23, 6'h00, 1, 5, 0, 0, 0, mk(1,2'b00,5,1,1,0,1,0,4'h7,0,3,0,0));
    applyStimulus("ADD bubble",1, 6'h00, 6'h20, 5, 1, 6, 0, 1, nop(0));
    applyStimulus("ADD r6",    1, 6'h00, 6'h20, 5, 1, 6, 0, 0, mk(1,2'b01,6,0,0,0,0,0,4'h0,7,3,0,0));
    applyStimulus("LW r5 b",   1, 6'h23, 6'h00, 1, 5, 0, 0, 0, mk(1,2'b00,5,1,1,0,1,0,4'h7,0,3,0,0));
    applyStimulus("SW bubble", 1, 6'h2B, 6'h00, 2, 5, 0, 0, 1, nop(0));
    applyStimulus("SW r5",     1, 6'h2B, 6'h00, 2, 5, 0, 0, 0, mk(0,2'b00,0,1,0,1,0,0,4'h7,7,0,0,0));
    applyStimulus("LW r5 c",   1, 6'h23, 6'h00, 1, 5, 0, 0, 0, mk(1,2'b00,5,1,1,0,1,0,4'h7,0,3,0,0));
    applyStimulus("ADDI bub",  1, 6'h08, 6'h00, 5, 7, 0, 0, 1, nop(0));
    applyStimulus("ADDI r7",   1, 6'h08, 6'h00, 5, 7, 0, 0, 0, mk(1,2'b00,7,1,0,0,0,0,4'h9,7,3,0,0));
    applyStimulus("LW r5 d",   1, 6'h23, 6'h00, 1, 5, 0, 0, 0, mk(1,2'b00,5,1,1,0,1,0,4'h7,0,3,0,0));
    applyStimulus("ORI r5",    1, 6'h0D, 6'h00, 3, 5, 0, 0, 0, mk(1,2'b00,5,1,0,0,0,0,4'hB,7,3,0,0));
    applyStimulus("LW r5 e",   1, 6'h23, 6'h00, 1, 5, 0, 0, 0, mk(1,2'b00,5,1,1,0,1,0,4'h7,0,3,0,0));
    applyStimulus("ADD flush", 1, 6'h00, 6'h20, 5, 1, 6, 1, 0, nop(0));
    applyStimulus("ADD after", 1, 6'h00, 6'h20, 5, 1, 6, 0, 0, mk(1,2'b01,6,0,0,0,0,0,4'h0,7,3,0,0));

    // MULT then MFLO: three stalled cycles, MFLO advances at edge t+4
    applyStimulus("MULT a",   1, 6'h00, 6'h18, 1, 2, 0, 0, 0, mk(1,2'b01,0,0,0,0,0,0,4'h0,7,3,1,1));
    applyStimulus("MFLO w1",  1, 6'h00, 6'h12, 0, 0, 10, 0, 1, nop(1));
    applyStimulus("MFLO w2",  1, 6'h00, 6'h12, 0, 0, 10, 0, 1, nop(1));
    applyStimulus("MFLO w3",  1, 6'h00, 6'h12, 0, 0, 10, 0, 1, nop(1));
    applyStimulus("MFLO go",  1, 6'h00, 6'h12, 0, 0, 10, 0, 0, mk(1,2'b01,10,0,0,0,0,0,4'h0,7,3,0,0));

    // MULT, independent ORI proceeds, then MFLO waits the remainder
    applyStimulus("MULT b",   1, 6'h00, 6'h18, 1, 2, 0, 0, 0, mk(1,2'b01,0,0,0,0,0,0,4'h0,7,3,1,1));
    applyStimulus("ORI busy", 1, 6'h0D, 6'h00, 1, 9, 0, 0, 0, mk(1,2'b00,9,1,0,0,0,0,4'hB,7,3,0,1));
    applyStimulus("MFLO x1",  1, 6'h00, 6'h12, 0, 0, 10, 0, 1, nop(1));
    applyStimulus("MFLO x2",  1, 6'h00, 6'h12, 0, 0, 10, 0, 1, nop(1));
    applyStimulus("MFLO xgo", 1, 6'h00, 6'h12, 0, 0, 10, 0, 0, mk(1,2'b01,10,0,0,0,0,0,4'h0,7,3,0,0));

    // Flush kills a DIV in ID; flush does not stop an issued op counting
    applyStimulus("DIV flush", 1, 6'h00, 6'h1A, 1, 2, 0, 1, 0, nop(0));
    applyStimulus("idle",      0, 6'h00, 6'h00, 0, 0, 0, 0, 0, nop(0));
    applyStimulus("MULT c",    1, 6'h00, 6'h18, 1, 2, 0, 0, 0, mk(1,2'b01,0,0,0,0,0,0,4'h0,7,3,1,1));
    applyStimulus("MFLO fl",   1, 6'h00, 6'h12, 0, 0, 10, 1, 0, nop(1));
    applyStimulus("count 2",   0, 6'h00, 6'h00, 0, 0, 0, 0, 0, nop(1));
    applyStimulus("count 1",   0, 6'h00, 6'h00, 0, 0, 0, 0, 0, nop(1));
    applyStimulus("count 0",   0, 6'h00, 6'h00, 0, 0, 0, 0, 0, nop(0));

    // Reset while MULT/DIV is busy
    applyStimulus("MULT d",    1, 6'h00, 6'h19, 1, 2, 0, 0, 0, mk(1,2'b01,0,0,0,0,0,0,4'h0,7,3,1,1));
    @(negedge clk);
    id_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("reset mid-op busy", 32'(md_busy), 32'd0);
    checkOutput("reset mid-op word", 32'(actual_word()), 32'(nop(1'b0)));
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("post reset", 0, 6'h00, 6'h00, 0, 0, 0, 0, 0, nop(0));

    @(negedge clk);
    checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Registered control unit for the 5-stage MIPS pipeline; sits between the IF/ID register and the ID/EX register.
- Decodes opcode/funct/rt into the EX-stage control word, using the standard MIPS encodings from definition.v.
- Detects load-use hazards and inserts one bubble.
- Tracks the multi-cycle MULT/DIV unit and stalls dependent HI/LO accesses.
- Handles branch flush.

Parameters:
MD_LATENCY, 4, MULT/DIV occupancy in cycles (legal range 1..15)
ALUOP_W, 4, width of ALU operation code
RA_W, 5, register address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
id_valid  in  1  instruction in ID is valid
id_opcode  in  6  instr[31:26]
id_funct  in  6  instr[5:0]
id_rs  in  RA_W  instr[25:21]
id_rt  in  RA_W  instr[20:16]
id_rd  in  RA_W  instr[15:11]
flush  in  1  branch taken in EX; kill the ID instruction
stall_id  out  1  hold PC and IF/ID (combinational)
md_busy  out  1  MULT/DIV unit occupied (registered)
ex_reg_write  out  1  registered control word follows (ex_*)
ex_reg_dst  out  2  00 rt, 01 rd, 10 r31
ex_wreg  out  RA_W  resolved destination; 0 when ex_reg_write=0
ex_alu_src  out  1  1 = immediate operand
ex_mem_read  out  1
ex_mem_write  out  1
ex_mem_to_reg  out  1
ex_branch  out  1
ex_alu_op  out  ALUOP_W
ex_load_op  out  3
ex_save_op  out  2
ex_md_start  out  1  MULT/DIV issued this cycle

Behaviour:
- Reset (async, while rst=1):
  - All ex_* single bits 0, ex_wreg 0, ex_reg_dst 00.
  - ex_alu_op 4'b1111, ex_load_op 3'b111, ex_save_op 2'b11.
  - md_cnt 0, md_busy 0.
  - Reset mid-MULT/DIV abandons the operation.
- Decode (combinational from id_*):
  - R-type (000000): reg_write=1, dst=rd, alu_op 0000. JR: reg_write=0. JALR: dst=rd.
  - ADDI/ADDIU 1001, ANDI 1010, ORI 1011, XORI 1100, SLTI/SLTIU 1101, LUI 1000. All of these: alu_src=1, dst=rt, reg_write=1. Each opcode maps to exactly one alu_op; no overlap with R-type.
  - Loads/stores: alu_op 0111, alu_src=1.
    - load_op: LW 000, LB 001, LBU 010, LH 011, LHU 100.
    - save_op: SW 00, SB 01, SH 10.
    - Loads: mem_read=1, mem_to_reg=1, reg_write=1, dst=rt.
  - Branches: branch=1, reg_write=0.
    - alu_op: BEQ 0001, BNE 0110, BGTZ 0011, BLEZ 0100.
    - REGIMM with rt=00001 (BGEZ): 0010; rt=00000 (BLTZ): 0101.
  - JAL: reg_write=1, dst=r31.
  - Unknown opcode: NOP word (reset values).
- rt_used: R-type, BEQ, BNE, stores.
- Load-use stall:
  - Condition: id_valid & ex_mem_read & ex_wreg!=0 & (ex_wreg==id_rs | (rt_used & ex_wreg==id_rt)).
  - Asserts stall_id for exactly one cycle; the next ex_* word is a NOP bubble.
- HI/LO stall:
  - Condition: id_valid & md_busy & ID holds MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
  - stall_id asserts with a bubble until md_busy falls.
  - Other instructions proceed while the unit is busy.
- MULT/DIV issue:
  - When MULT/MULTU/DIV/DIVU advances from ID: ex_md_start=1 for one cycle, md_cnt loads MD_LATENCY.
  - md_busy = (md_cnt!=0). md_cnt decrements each cycle, saturating at 0.
  - Issue at edge t: md_busy is high for cycles t..t+MD_LATENCY-1. The first dependent instruction advances at edge t+MD_LATENCY.
- Flush: highest priority.
  - stall_id=0; next ex_* word is NOP.
  - A MULT/DIV in ID is not issued.
  - md_cnt of an already-issued op keeps counting.
- Advance rule: when !flush & !stall_id & id_valid, decoded word is registered into ex_*. Otherwise a NOP is registered.
- Simultaneous load-use and HI/LO stall: a single stall_id; each cycle is re-evaluated.

Optional Feature:
- Macro: CTRL_ILLEGAL_EN.
- When defined:
  - Adds output ex_illegal (1 bit, reset 0).
  - Registered high for one cycle when a valid, unflushed, unstalled instruction has an unknown opcode, or an unknown funct under R-type.
  - The accompanying ex_* word is a NOP.
- When undefined:
  - Port is absent.
  - Unknown encodings silently decode to NOP.

Test Plan:
- Reset mid-operation: rst=1 during md_busy -> md_busy=0 immediately; ex_alu_op=1111, ex_load_op=111, ex_save_op=11.
- Load-use: LW r5 followed by ADD r6,r5,r1 -> stall_id=1 for exactly one cycle; the cycle after has ex_reg_write=0 bubble; ADD issues next with ex_wreg=6, ex_alu_op 0000.
- Store-rt hazard: LW r5 followed by SW r5,0(r2) -> stall. LW r5 followed by ADDI r7,r5... hazard via rs -> stall. LW r5 followed by ORI r5,r3 (rt not a source) -> no stall.
- MULT then MFLO, MD_LATENCY=4: MULT issues at edge t (ex_md_start=1); MFLO waits three cycles and advances at edge t+4. An intervening ORI proceeds unstalled.
- Flush: flush=1 together with DIV in ID -> ex_md_start stays 0, md_busy stays 0, ex_* is NOP. Flush during an active load-use condition -> stall_id=0.
- Decode sweep: every opcode listed, plus BGEZ/BLTZ via rt -> exact alu_op/load_op/save_op values. Opcode 111111 -> NOP; ex_illegal pulses when CTRL_ILLEGAL_EN is defined.
